// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmitter slice.
package i2s_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

    // System clocks per full left+right frame.
    function automatic int unsigned clks_per_frame(input int unsigned bclk_div,
                                                   input int unsigned slot_bits);
        return 4 * bclk_div * slot_bits;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk_o every bclk_div_p system clocks and flags
// the cycle in which bclk_o is being registered 1->0.
module i2s_bclk_gen #(
    parameter int unsigned bclk_div_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic bclk_o,
    output logic fall_o
);

    localparam int unsigned cnt_w = (bclk_div_p > 1) ? $clog2(bclk_div_p) : 1;

    logic [cnt_w-1:0] cnt;
    logic             term;

    assign term   = (cnt == cnt_w'(bclk_div_p - 1));
    assign fall_o = term & bclk_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt    <= '0;
            bclk_o <= 1'b0;
        end else if (term) begin
            cnt    <= '0;
            bclk_o <= ~bclk_o;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S DAC transmitter: single-entry hold buffer feeding a per-slot shift
// register, MSB first with the standard one-bit delay after word-select.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned width_p     = 24,
    parameter int unsigned bclk_div_p  = 4,
    parameter int unsigned slot_bits_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               bclk_o,
    output logic               lrclk_o,
    output logic               sdata_o,
    output logic               underrun_o
);

    localparam int unsigned pos_w = $clog2(slot_bits_p);

    logic               fall;
    logic               hold_valid;
    logic [width_p-1:0] hold_data;
    logic [width_p-1:0] shift;
    logic [pos_w-1:0]   pos;
    logic               wrap;
    channel_e           channel;

    i2s_bclk_gen #(
        .bclk_div_p(bclk_div_p)
    ) u_bclk_gen (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .bclk_o (bclk_o),
        .fall_o (fall)
    );

    assign ready_o = ~hold_valid;
    assign wrap    = (pos == pos_w'(slot_bits_p - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            shift      <= '0;
            pos        <= pos_w'(slot_bits_p - 1);
            channel    <= CH_RIGHT;
            lrclk_o    <= 1'b0;
            sdata_o    <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= 1'b0;

            // Fill and drain never coincide: filling needs the buffer empty,
            // draining needs it full.
            if (valid_i && ready_o) begin
                hold_valid <= 1'b1;
                hold_data  <= data_i;
            end

            if (fall) begin
                if (wrap) begin
                    pos     <= '0;
                    channel <= (channel == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                    lrclk_o <= (channel == CH_LEFT);
                    sdata_o <= 1'b0;
                    if (hold_valid) begin
                        shift      <= hold_data;
                        hold_valid <= 1'b0;
                    end else begin
                        shift      <= '0;
                        underrun_o <= 1'b1;
                    end
                end else begin
                    pos <= pos + 1'b1;
                    // New position pos+1 lies in 1..width_p exactly when pos < width_p.
                    if (pos < pos_w'(width_p)) begin
                        sdata_o <= shift[width_p-1];
                        shift   <= shift << 1;
                    end else begin
                        sdata_o <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
